// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU. Commands are queued in a small FIFO, the head drives the ALU,
// and the ALU outputs are captured into a result register handed out over valid/ready.
module alu_cmd_sequencer #(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [3:0]       cmd_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_res,
  input  logic             alu_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_carry,
  output logic             res_dz,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [0:0] {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_e;

  function automatic logic calc_dz(input logic [3:0] op, input logic [7:0] b);
    return (op == 4'b0011) && (b == 8'd0);
  endfunction

  function automatic logic [7:0] calc_data(input logic dz, input logic [7:0] res);
    return dz ? 8'hFF : res;
  endfunction

  function automatic logic calc_carry(input logic [3:0] op, input logic cout);
    return (op == 4'b0000) ? cout : 1'b0;
  endfunction

  logic [7:0]       mem_a_q  [DEPTH];
  logic [7:0]       mem_b_q  [DEPTH];
  logic [3:0]       mem_op_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  res_state_e       state_q, state_d;
  logic [7:0]       res_data_q;
  logic             res_carry_q;
  logic             res_dz_q;
  logic             res_valid_s;
  logic             cmd_ready_s;
  logic             head_present_s;
  logic             push_s;
  logic             load_s;
  logic             head_dz_s;

  // Handshake qualifiers; cmd_ready only looks at the registered count
  always_comb begin
    cmd_ready_s    = (count_q < CNT_W'(DEPTH));
    head_present_s = (count_q != {CNT_W{1'b0}});
    push_s         = cmd_valid && cmd_ready_s;
    load_s         = head_present_s && (!res_valid_s || res_ready);
  end

  // ALU is driven from FIFO storage, zeros when nothing is queued
  always_comb begin
    if (head_present_s) begin
      alu_a   = mem_a_q[rd_ptr_q];
      alu_b   = mem_b_q[rd_ptr_q];
      alu_sel = mem_op_q[rd_ptr_q];
    end else begin
      alu_a   = 8'd0;
      alu_b   = 8'd0;
      alu_sel = 4'd0;
    end
  end

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = load_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_s, load_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a_q[i]  <= 8'd0;
        mem_b_q[i]  <= 8'd0;
        mem_op_q[i] <= 4'd0;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_a_q[wr_ptr_q]  <= cmd_a;
        mem_b_q[wr_ptr_q]  <= cmd_b;
        mem_op_q[wr_ptr_q] <= cmd_op;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Result register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RES_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Result register next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RES_EMPTY: begin
        if (load_s) state_d = RES_FULL;
        else        state_d = RES_EMPTY;
      end
      RES_FULL: begin
        if (load_s)         state_d = RES_FULL;
        else if (res_ready) state_d = RES_EMPTY;
        else                state_d = RES_FULL;
      end
      default: state_d = RES_EMPTY;
    endcase
  end

  // Result register state decode
  always_comb begin
    res_valid_s = 1'b0;
    case (state_q)
      RES_EMPTY: res_valid_s = 1'b0;
      RES_FULL:  res_valid_s = 1'b1;
      default:   res_valid_s = 1'b0;
    endcase
  end

  // The dz flag overrides whatever quotient the ALU produces for a zero divisor
  always_comb begin
    head_dz_s = calc_dz(alu_sel, alu_b);
  end

  // Result payload capture; held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q  <= 8'd0;
      res_carry_q <= 1'b0;
      res_dz_q    <= 1'b0;
    end else if (load_s) begin
      res_data_q  <= calc_data(head_dz_s, alu_res);
      res_carry_q <= calc_carry(alu_sel, alu_cout);
      res_dz_q    <= head_dz_s;
    end else begin
      res_data_q  <= res_data_q;
      res_carry_q <= res_carry_q;
      res_dz_q    <= res_dz_q;
    end
  end

  assign cmd_ready  = cmd_ready_s;
  assign res_valid  = res_valid_s;
  assign res_data   = res_data_q;
  assign res_carry  = res_carry_q;
  assign res_dz     = res_dz_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU on the alu_* ports, expected results kept in a queue
// computed from each accepted command, plus directed latency/backpressure/reset steps.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [3:0] cmd_op;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_res;
  logic       alu_cout;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       res_carry, res_dz;
  logic [2:0] fifo_count;

  int n_pass  = 0;
  int n_total = 0;
  logic [9:0] exp_q[$];   // {dz, carry, data}

  logic       stall_q = 1'b0;
  logic [9:0] held_q  = 10'd0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_dz(res_dz),
    .fifo_count(fifo_count)
  );

  // Stand-in combinational ALU: {cout, result}
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {^a, p[7:0]};
      4'd3:    return (b == 8'd0) ? {^a, 8'h5A} : {^a, a / b};
      4'd4:    return {^b, a & b};
      4'd5:    return {^b, a | b};
      4'd6:    return {^b, a ^ b};
      4'd7:    return {1'b1, ~a};
      4'd8:    return {a[7], a[6:0], 1'b0};
      4'd9:    return {a[0], 1'b0, a[7:1]};
      4'd10:   return {1'b0, a} + 9'd1;
      4'd11:   return {1'b0, a} - 9'd1;
      4'd12:   return {1'b1, b};
      4'd13:   return {1'b1, a};
      4'd14:   return {^a, ~(a & b)};
      default: return {^b, ~(a ^ b)};
    endcase
  endfunction

  // Expected captured payload for one command
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [8:0] r;
    logic       dz;
    r  = alu_fn(a, b, op);
    dz = (op == 4'd3) && (b == 8'd0);
    return {dz, (op == 4'd0) ? r[8] : 1'b0, dz ? 8'hFF : r[7:0]};
  endfunction

  assign {alu_cout, alu_res} = alu_fn(alu_a, alu_b, alu_sel);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int guard;
    guard     = 0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (!cmd_ready) chk("send_timeout", 32'd0, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard     = 0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || fifo_count != 3'd0 || res_valid) && guard < 300) begin
      tick();
      guard++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: outputs compared against the queue head, payload hold checked during stalls
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_q && res_valid) chk("hold_payload", 32'({res_dz, res_carry, res_data}), 32'(held_q));
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", 32'd1, 32'd0);
        end else begin
          chk("res_data", 32'(res_data), 32'(exp_q[0][7:0]));
          chk("res_carry", 32'(res_carry), 32'(exp_q[0][8]));
          chk("res_dz", 32'(res_dz), 32'(exp_q[0][9]));
          if (res_ready) void'(exp_q.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_a, cmd_b, cmd_op));
      stall_q <= res_valid && !res_ready;
      held_q  <= {res_dz, res_carry, res_data};
    end else begin
      stall_q <= 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int cyc;
    logic [3:0] ops [5];
    ops = '{4'b0001, 4'b1000, 4'b1001, 4'b1010, 4'b1111};

    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
    cmd_a = 8'd0; cmd_b = 8'd0; cmd_op = 4'd0;
    tick(); tick();
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_carry", 32'(res_carry), 32'd0);
    chk("rst_res_dz", 32'(res_dz), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    rst_n = 1'b1;
    tick();

    // single add: result visible after the edge following acceptance, for one cycle
    cmd_a = 8'd200; cmd_b = 8'd100; cmd_op = 4'b0000; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("add_count_after_accept", 32'(fifo_count), 32'd1);
    chk("add_valid_early", 32'(res_valid), 32'd0);
    chk("add_alu_drive", 32'({alu_a, alu_b, alu_sel}), {12'd0, 8'd200, 8'd100, 4'd0});
    tick();
    chk("add_valid", 32'(res_valid), 32'd1);
    chk("add_data", 32'(res_data), 32'd44);
    chk("add_carry", 32'(res_carry), 32'd1);
    chk("add_dz", 32'(res_dz), 32'd0);
    chk("add_count_after_load", 32'(fifo_count), 32'd0);
    chk("add_alu_idle", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    tick();
    chk("add_valid_one_cycle", 32'(res_valid), 32'd0);

    // divide by zero, then a normal divide
    send(8'd50, 8'd0, 4'b0011);
    tick();
    chk("dz_data", 32'(res_data), 32'hFF);
    chk("dz_flag", 32'(res_dz), 32'd1);
    chk("dz_carry", 32'(res_carry), 32'd0);
    send(8'd50, 8'd7, 4'b0011);
    tick();
    chk("div_data", 32'(res_data), 32'd7);
    chk("div_flag", 32'(res_dz), 32'd0);
    drain();

    // backpressure: result register occupied, then fill the FIFO
    res_ready = 1'b0;
    send(8'd1, 8'd2, 4'b0000);
    tick();
    chk("bp_prefill_valid", 32'(res_valid), 32'd1);
    for (int i = 0; i < 4; i++) send(8'($urandom()), 8'($urandom()), ops[i]);
    chk("bp_full_count", 32'(fifo_count), 32'd4);
    chk("bp_full_ready", 32'(cmd_ready), 32'd0);
    cmd_a = 8'($urandom()); cmd_b = 8'($urandom()); cmd_op = ops[4]; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stalled_ready", 32'(cmd_ready), 32'd0);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_ready_ignores_pop", 32'(cmd_ready), 32'd0);
    tick();
    chk("bp_ready_after_pop", 32'(cmd_ready), 32'd1);
    chk("bp_count_after_pop", 32'(fifo_count), 32'd3);
    tick();
    cmd_valid = 1'b0;
    chk("bp_count_push_pop", 32'(fifo_count), 32'd3);
    drain();

    // continuous stream at full throughput
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cmd_a = 8'($urandom()); cmd_b = 8'($urandom()); cmd_op = 4'($urandom());
      tick();
      chk("stream_count_le1", 32'(fifo_count <= 3'd1), 32'd1);
      if (i >= 1) chk("stream_valid", 32'(res_valid), 32'd1);
    end
    cmd_valid = 1'b0;
    drain();

    // random traffic with random backpressure
    acc = 0;
    cyc = 0;
    while (acc < 200 && cyc < 5000) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_a     = 8'($urandom());
      cmd_b     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom());
      cmd_op    = ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom());
      res_ready = ($urandom_range(0, 1) == 1);
      if (cmd_valid && cmd_ready) acc++;
      tick();
      cyc++;
    end
    cmd_valid = 1'b0;
    chk("rand_accepted", 32'(acc), 32'd200);
    drain();

    // reset with work in flight
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'($urandom()), 8'($urandom()), 4'($urandom()));
    chk("mid_count", 32'(fifo_count), 32'd3);
    chk("mid_valid", 32'(res_valid), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_payload", 32'({res_dz, res_carry, res_data}), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_valid", 32'(res_valid), 32'd0);
      chk("post_rst_count", 32'(fifo_count), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream issue stage for the 8-bit combinational ALU: accepts operation commands over a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Presents the FIFO head to the ALU, samples the ALU result and carry into an output register, and returns them over a valid/ready result interface.
- Adds divide-by-zero detection and gives defined values where the ALU alone has none.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_op  in  4  ALU select code.
- alu_a  out  8  to ALU input A.
- alu_b  out  8  to ALU input B.
- alu_sel  out  4  to ALU select input.
- alu_res  in  8  from ALU result output.
- alu_cout  in  1  from ALU carry output.
- res_valid  out  1  result register holds a result.
- res_ready  in  1  consumer accepts the result.
- res_data  out  8  registered result.
- res_carry  out  1  registered carry.
- res_dz  out  1  registered divide-by-zero flag.
- fifo_count  out  CNT_W  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, fifo_count=0.
  - res_valid=0, res_data=0, res_carry=0, res_dz=0.
  - cmd_ready=1 once the FIFO is empty.
  - Reset mid-operation discards all queued and registered commands; nothing is reported for them.
- Command accept: push when cmd_valid && cmd_ready at the rising edge.
  - cmd_ready = (fifo_count < DEPTH); registered-count based, with no combinational path from res_ready.
  - When full, cmd_ready=0 even in a cycle where a pop occurs.
- ALU drive:
  - FIFO non-empty: alu_a/alu_b/alu_sel equal the head entry, combinationally from FIFO storage.
  - FIFO empty: alu_a=0, alu_b=0, alu_sel=0.
- Result register: two states, EMPTY (res_valid=0) and FULL (res_valid=1).
  - load = head_present && (!res_valid || res_ready).
  - On load: capture ALU outputs, pop the head, state becomes FULL.
  - FULL && res_ready && !load: state becomes EMPTY.
  - FULL && res_ready && load: stays FULL with the new data, giving back-to-back throughput of 1 result/cycle.
  - FULL && !res_ready: hold res_data/res_carry/res_dz stable; no pop.
- Captured values:
  - res_dz = (head op == 4'b0011) && (head B == 0).
  - When res_dz=1, res_data = 8'hFF (ALU quotient ignored); otherwise res_data = alu_res.
  - res_carry = alu_cout only when head op == 4'b0000; otherwise 0.
- Latency: a command accepted at edge k drives the ALU after edge k. The result is loaded at edge k+1, so res_valid is high from edge k+1 onward if the result register was free.
- Simultaneous push and pop: fifo_count unchanged; pointers both advance, wrapping modulo DEPTH.
- Push into an empty FIFO cannot be loaded in the same edge; data must first be written into FIFO storage.
- Ordering is strict FIFO; no reordering, no dropping, no command duplication.

Test Plan:
- Reset, then a single cmd A=8'd200, B=8'd100, op=0000 with res_ready=1 -> res_valid exactly 1 cycle, 2 edges after accept; res_data=8'd44, res_carry=1, res_dz=0.
- Divide A=8'd50, B=0, op=0011 -> res_data=8'hFF, res_dz=1, res_carry=0. Then A=8'd50, B=8'd7, op=0011 -> res_data=8'd7, res_dz=0.
- Hold res_ready=0 and push 5 cmds (ops 0001, 1000, 1001, 1010, 1111) -> cmd_ready drops after 4 accepts and fifo_count=4. The 5th is accepted only after res_ready rises. Results emerge in order, with res_data stable while stalled.
- Continuous stream of 16 cmds with res_ready=1 and cmd_valid=1 -> one result per cycle after the first; fifo_count never exceeds 1; every result matches the golden ALU model.
- Random res_ready toggling over 200 random cmds -> no loss or duplication; results in order; payload unchanged while res_valid && !res_ready.
- Assert rst_n low with the FIFO at 3 entries and res_valid=1 -> outputs go to reset values immediately. After release fifo_count=0, and no stale result appears.
